// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch
// and the load/store stage, alternating priority when both stages contend.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          me_req,
  input  logic          me_we,
  input  logic [AW-1:0] me_addr,
  input  logic [DW-1:0] me_wdata,
  output logic [DW-1:0] me_rdata,
  output logic          me_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_me
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    state_t        state;
    logic          owner;    // 0 = IF, 1 = ME
    logic [3:0]    cnt;
    logic          last_me;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          if_ready;
    logic          me_ready;
    logic [DW-1:0] if_rdata;
    logic [DW-1:0] me_rdata;
  } regs_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  regs_t r, r_nxt;
  logic  grant_me;

  // NOTE: reset is sampled on the clock edge, so an access in flight is simply
  // dropped; every register, including the read-data copies, returns to zero.
  always_ff @(posedge clock) begin
    if (reset) r <= '0;
    else       r <= r_nxt;
  end

  // NOTE: start from the current register values so every field of r_nxt is
  // assigned on every path and no latch can be inferred.
  always_comb begin
    r_nxt          = r;
    r_nxt.if_ready = 1'b0;
    r_nxt.me_ready = 1'b0;
    grant_me       = me_req && (!if_req || !r.last_me);
    unique case (r.state)
      IDLE: begin
        if (me_req || if_req) begin
          r_nxt.state     = BUSY;
          r_nxt.cnt       = LAT_M1;
          r_nxt.owner     = grant_me;
          r_nxt.last_me   = grant_me;
          r_nxt.mem_en    = 1'b1;
          r_nxt.mem_we    = grant_me & me_we;
          r_nxt.mem_addr  = grant_me ? me_addr : if_addr;
          r_nxt.mem_wdata = grant_me ? me_wdata : '0;
        end
      end
      BUSY: begin
        if (r.cnt == 4'd0) begin
          r_nxt.state  = DONE;
          r_nxt.mem_en = 1'b0;
          r_nxt.mem_we = 1'b0;
          if (r.owner) begin
            r_nxt.me_rdata = mem_rdata;
            r_nxt.me_ready = 1'b1;
          end else begin
            r_nxt.if_rdata = mem_rdata;
            r_nxt.if_ready = 1'b1;
          end
        end else begin
          r_nxt.cnt = r.cnt - 4'd1;
        end
      end
      DONE:    r_nxt.state = IDLE;
      default: r_nxt.state = IDLE;
    endcase
  end

  assign mem_en    = r.mem_en;
  assign mem_we    = r.mem_we;
  assign mem_addr  = r.mem_addr;
  assign mem_wdata = r.mem_wdata;
  assign if_ready  = r.if_ready;
  assign me_ready  = r.me_ready;
  assign if_rdata  = r.if_rdata;
  assign me_rdata  = r.me_rdata;

  // Stalls react in the same cycle the request is raised.
  assign stall_if  = if_req & ~r.if_ready;
  assign stall_me  = me_req & ~r.me_ready;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Sequences each access through a small FSM.
- Returns read data and a one-cycle ready pulse to the granted stage.
- Drives stall outputs that freeze the pipeline while an access is pending.

Parameters:
MEM_LAT, 2, cycles mem_en is held per access (legal range 1..15)
AW, 32, address width
DW, 32, data width

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
if_req  input  1  IF fetch request; held high until if_ready
if_addr  input  AW  fetch address
if_rdata  output  DW  fetched instruction, valid while if_ready=1
if_ready  output  1  one-cycle completion pulse for IF
me_req  input  1  MEM-stage access request; held until me_ready
me_we  input  1  1=store, 0=load
me_addr  input  AW  data address
me_wdata  input  DW  store data
me_rdata  output  DW  load data, valid while me_ready=1
me_ready  output  1  one-cycle completion pulse for MEM
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid in last mem_en cycle
stall_if  output  1  if_req & ~if_ready (combinational)
stall_me  output  1  me_req & ~me_ready (combinational)

Behaviour:
- FSM states: IDLE, BUSY, DONE. Register owner (0=IF, 1=ME), counter cnt[3:0], flag last_me.
- Reset (sync, high): state=IDLE, cnt=0, owner=0, last_me=0. All registered outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_ready, me_ready, if_rdata, me_rdata. Reset mid-access aborts without completion; no ready pulse follows.
- IDLE arbitration, sampled at rising edge:
  - Only me_req: grant ME.
  - Only if_req: grant IF.
  - Both: grant ME unless last_me=1, in which case grant IF (anti-starvation alternation).
  - Neither: stay IDLE.
  - On grant: state=BUSY, cnt=MEM_LAT-1, owner set, last_me=(owner==ME), and mem_* registers loaded from the granted requester. IF accesses force mem_we=0 and mem_wdata=0.
- BUSY:
  - mem_en=1 with mem_we/addr/wdata held constant for exactly MEM_LAT cycles.
  - When cnt==0: latch mem_rdata into owner's rdata register (stores latch mem_rdata as-is; value don't-care to pipeline). Then state=DONE, mem_en=0, mem_we=0, owner's ready=1.
  - Otherwise cnt decrements.
- DONE: exactly one cycle with owner's ready=1, then state=IDLE and ready=0. Requests are not sampled in BUSY or DONE; the earliest next grant is the edge that ends the first IDLE cycle.
- Latency: request sampled at edge N → mem_en high in cycles N+1..N+MEM_LAT → ready high in cycle N+MEM_LAT+1. Back-to-back accesses occupy MEM_LAT+2 cycles each.
- rdata registers hold their last value after ready drops. Only the owner's rdata is updated.
- Requester inputs changing during BUSY are ignored; the registered copy is used.
- A requester dropping its req before ready is a protocol violation. The access still completes and ready still pulses.
- Never both if_ready and me_ready in the same cycle.

Test Plan:
1. Reset held 3 cycles with both req=1, then released → all outputs 0 during reset; first mem_en appears 1 cycle after release edge with the ME address (alternation starts ME).
2. MEM_LAT=2, if_req only, if_addr=0x00000040, memory returns 0x8C080004 → mem_en high 2 cycles, mem_we=0, if_ready pulse at cycle 3 after grant, if_rdata=0x8C080004, stall_if=1 until then.
3. Store: me_req=1, me_we=1, me_addr=0x00000100, me_wdata=0xDEADBEEF → mem_we=1 and mem_wdata=0xDEADBEEF for 2 cycles, me_ready pulses once, if_ready stays 0.
4. Both req held continuously → grant order ME, IF, ME, IF; each grant spans 4 cycles; ready pulses alternate and never coincide.
5. Assert reset in 2nd BUSY cycle of a load → next cycle state IDLE, mem_en=0, no me_ready pulse; re-request completes normally.
6. MEM_LAT=1, back-to-back if_req with addresses 0x0, 0x4 → mem_en 1 cycle each, if_ready pulses 3 cycles apart, if_rdata matches each word.
